// File: rtl/fetch_unit.sv
// RV32 instruction-fetch front end: owns the PC, reads a combinational imem and
// presents {pc, instr} to decode through a one-entry valid/ready output slot.
module fetch_unit #(
  parameter int ADDR_W   = 12,
  parameter int RESET_PC = 0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted,
  output logic              misalign_err,
  output logic [CNT_W-1:0]  fetch_count
);

  // state | meaning
  // BOOT  | one idle cycle after reset, no fetch
  // RUN   | fetching, slot loads whenever it is empty or being drained
  // HALT  | zero word or last address fetched; waits for an aligned redirect
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  localparam logic [ADDR_W-1:0] LAST_PC = {{(ADDR_W-2){1'b1}}, 2'b00};

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  pc, pc_nxt;
  logic               valid_nxt;
  logic [31:0]        instr_nxt;
  logic [ADDR_W-1:0]  opc_nxt;
  logic               redir_ok, redir_bad, load, handshake;

  assign imem_addr = pc;
  assign halted    = (state == HALT);
  assign handshake = out_valid & out_ready;
  assign redir_ok  = redirect_valid & (redirect_pc[1:0] == 2'b00);
  assign redir_bad = redirect_valid & (redirect_pc[1:0] != 2'b00);
  assign load      = (state == RUN) & (!out_valid | out_ready) & !redir_ok & !flush;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    valid_nxt = out_valid;
    instr_nxt = out_instr;
    opc_nxt   = out_pc;
    if (redir_ok) begin
      pc_nxt    = redirect_pc;
      valid_nxt = 1'b0;
      state_nxt = RUN;
    end else if (flush) begin
      valid_nxt = 1'b0;
      if (state == BOOT) state_nxt = RUN;
    end else begin
      if (state == BOOT) state_nxt = RUN;
      if (load) begin
        instr_nxt = imem_data;
        opc_nxt   = pc;
        valid_nxt = 1'b1;
        // the last word never advances the PC, so no wrap-around is possible
        pc_nxt    = (pc == LAST_PC) ? pc : pc + ADDR_W'(4);
        if (imem_data == 32'h0 || pc == LAST_PC) state_nxt = HALT;
      end else if (out_ready) begin
        valid_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= BOOT;
      pc           <= ADDR_W'(RESET_PC);
      out_valid    <= 1'b0;
      out_instr    <= 32'h0;
      out_pc       <= '0;
      misalign_err <= 1'b0;
      fetch_count  <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      out_valid <= valid_nxt;
      out_instr <= instr_nxt;
      out_pc    <= opc_nxt;
      if (redir_bad) misalign_err <= 1'b1;
      if (handshake && fetch_count != {CNT_W{1'b1}})
        fetch_count <= fetch_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// stream compared against a program-order scoreboard.
module tb_fetch_unit;
  localparam int ADDR_W = 12;
  localparam int CNT_W  = 16;

  logic              clk = 0;
  logic              rst_n = 0;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic              redirect_valid = 0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              flush = 0;
  logic              out_valid;
  logic              out_ready = 0;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic              halted;
  logic              misalign_err;
  logic [CNT_W-1:0]  fetch_count;

  logic [31:0] mem [0:1023];
  int checks = 0;
  int failures = 0;

  assign imem_data = mem[imem_addr[ADDR_W-1:2]];

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(0), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .halted(halted), .misalign_err(misalign_err),
    .fetch_count(fetch_count));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 1024; i++) mem[i] = $urandom | 32'h1;
    rst_n = 0;
    #12;
    checks++;
    if ({out_valid, halted, misalign_err} !== 3'b000 || out_pc !== '0 ||
        out_instr !== 32'h0 || fetch_count !== '0 || imem_addr !== '0) begin
      failures++;
      $display("FAIL reset: valid=%0b halted=%0b err=%0b pc=%h instr=%h cnt=%0d addr=%h, want all zero",
               out_valid, halted, misalign_err, out_pc, out_instr, fetch_count, imem_addr);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_boot_stream();
    mem[0] = 32'h0050_0613;
    mem[1] = 32'h0606_0463;
    out_ready = 1;
    step();
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 12'h000) begin
      failures++;
      $display("FAIL boot_idle: valid=%0b addr=%h, want 0/000", out_valid, imem_addr);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 12'h000 || out_instr !== 32'h0050_0613) begin
      failures++;
      $display("FAIL first_fetch: valid=%0b pc=%h instr=%h, want 1/000/00500613", out_valid, out_pc, out_instr);
    end
    step();
    checks++;
    if (out_pc !== 12'h004 || out_instr !== 32'h0606_0463 || fetch_count !== 16'd1) begin
      failures++;
      $display("FAIL second_fetch: pc=%h instr=%h cnt=%0d, want 004/06060463/1", out_pc, out_instr, fetch_count);
    end
  endtask

  task automatic test_stall();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 12'h004 || imem_addr !== 12'h008 || fetch_count !== 16'd1) begin
        failures++;
        $display("FAIL stall_hold: valid=%0b pc=%h addr=%h cnt=%0d, want 1/004/008/1",
                 out_valid, out_pc, imem_addr, fetch_count);
      end
    end
    out_ready = 1;
    step();
    checks++;
    if (out_pc !== 12'h008 || out_instr !== mem[2] || fetch_count !== 16'd2) begin
      failures++;
      $display("FAIL stall_release: pc=%h instr=%h cnt=%0d, want 008/%h/2", out_pc, out_instr, fetch_count, mem[2]);
    end
  endtask

  task automatic test_redirect_flush();
    out_ready = 0; flush = 1; redirect_valid = 1; redirect_pc = 12'h024;
    step();
    flush = 0; redirect_valid = 0;
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 12'h024 || fetch_count !== 16'd2) begin
      failures++;
      $display("FAIL redirect_kill: valid=%0b addr=%h cnt=%0d, want 0/024/2", out_valid, imem_addr, fetch_count);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 12'h024 || out_instr !== mem[9]) begin
      failures++;
      $display("FAIL redirect_target: valid=%0b pc=%h instr=%h, want 1/024/%h", out_valid, out_pc, out_instr, mem[9]);
    end
    flush = 1;
    step();
    flush = 0;
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 12'h028) begin
      failures++;
      $display("FAIL flush: valid=%0b addr=%h, want 0/028", out_valid, imem_addr);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 12'h028 || imem_addr !== 12'h02C) begin
      failures++;
      $display("FAIL after_flush: valid=%0b pc=%h addr=%h, want 1/028/02c", out_valid, out_pc, imem_addr);
    end
  endtask

  task automatic test_misalign();
    redirect_valid = 1; redirect_pc = 12'h026;
    step();
    redirect_valid = 0;
    checks++;
    if (misalign_err !== 1'b1 || out_valid !== 1'b1 || out_pc !== 12'h028 || imem_addr !== 12'h02C) begin
      failures++;
      $display("FAIL misalign: err=%0b valid=%0b pc=%h addr=%h, want 1/1/028/02c",
               misalign_err, out_valid, out_pc, imem_addr);
    end
    out_ready = 1;
    repeat (3) step();
    checks++;
    if (misalign_err !== 1'b1 || out_pc !== 12'h034) begin
      failures++;
      $display("FAIL misalign_sticky: err=%0b pc=%h, want 1/034", misalign_err, out_pc);
    end
  endtask

  task automatic test_halt();
    mem[14] = 32'h0;
    redirect_valid = 1; redirect_pc = 12'h030;
    step();
    redirect_valid = 0;
    step(); step(); step();
    checks++;
    if (out_pc !== 12'h038 || out_instr !== 32'h0 || halted !== 1'b1 || imem_addr !== 12'h03C) begin
      failures++;
      $display("FAIL halt_zero: pc=%h instr=%h halted=%0b addr=%h, want 038/0/1/03c", out_pc, out_instr, halted, imem_addr);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || halted !== 1'b1 || imem_addr !== 12'h03C) begin
      failures++;
      $display("FAIL halt_drain: valid=%0b halted=%0b addr=%h, want 0/1/03c", out_valid, halted, imem_addr);
    end
    redirect_valid = 1; redirect_pc = 12'h000;
    step();
    redirect_valid = 0;
    step();
    checks++;
    if (halted !== 1'b0 || out_valid !== 1'b1 || out_pc !== 12'h000 || out_instr !== mem[0]) begin
      failures++;
      $display("FAIL halt_resume: halted=%0b valid=%0b pc=%h instr=%h, want 0/1/000/%h", halted, out_valid, out_pc, out_instr, mem[0]);
    end
    redirect_valid = 1; redirect_pc = 12'hFF8;
    step();
    redirect_valid = 0;
    step(); step();
    checks++;
    if (out_pc !== 12'hFFC || halted !== 1'b1 || imem_addr !== 12'hFFC) begin
      failures++;
      $display("FAIL halt_top: pc=%h halted=%0b addr=%h, want ffc/1/ffc", out_pc, halted, imem_addr);
    end
    step();
    checks++;
    if (imem_addr !== 12'hFFC || out_valid !== 1'b0 || misalign_err !== 1'b1) begin
      failures++;
      $display("FAIL no_wrap: addr=%h valid=%0b err=%0b, want ffc/0/1", imem_addr, out_valid, misalign_err);
    end
    mem[14] = 32'h1234_5677;
  endtask

  task automatic test_async_reset();
    out_ready = 0; redirect_valid = 1; redirect_pc = 12'h100;
    step();
    redirect_valid = 0;
    step();
    #3 rst_n = 0;
    #1;
    checks++;
    if ({out_valid, halted, misalign_err} !== 3'b000 || out_pc !== '0 ||
        out_instr !== 32'h0 || fetch_count !== '0 || imem_addr !== '0) begin
      failures++;
      $display("FAIL async_reset: valid=%0b halted=%0b err=%0b pc=%h instr=%h cnt=%0d addr=%h, want all zero",
               out_valid, halted, misalign_err, out_pc, out_instr, fetch_count, imem_addr);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  // Scoreboard: decode must see instructions in program order from the last
  // accepted redirect target, each carrying the memory word at its address.
  task automatic test_random_stream();
    logic [ADDR_W-1:0] exp_pc = '0;
    int hs = 0;
    int errs = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc = ADDR_W'($urandom_range(0, 255) << 2);
      #1;
      if (out_valid && out_ready) begin
        hs++;
        checks++;
        if (out_pc !== exp_pc || out_instr !== mem[out_pc[ADDR_W-1:2]]) begin
          failures++;
          errs++;
          if (errs < 5)
            $display("FAIL stream: pc=%h instr=%h, want %h/%h", out_pc, out_instr, exp_pc, mem[exp_pc[ADDR_W-1:2]]);
        end
        exp_pc = out_pc + ADDR_W'(4);
      end
      if (redirect_valid) exp_pc = redirect_pc;
      step();
    end
    redirect_valid = 0;
    checks++;
    if (fetch_count !== CNT_W'(hs) || hs < 100) begin
      failures++;
      $display("FAIL stream_count: count=%0d, want %0d (>=100)", fetch_count, hs);
    end
  endtask

  initial begin
    test_reset();
    test_boot_stream();
    test_stall();
    test_redirect_flush();
    test_misalign();
    test_halt();
    test_async_reset();
    test_random_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
